aes_in_stream: RTL and testbench
================================

Name: aes_in_stream

Overview:
- Upstream ingress stage for aes_controller.
- Accepts one AXI4-Stream packet per request: a 32-bit command word, then payload words. Packs payload into 128-bit blocks and stores them in an on-chip block buffer.
- Pulses the controller's start, then serves its synchronous block reads until the controller signals completion.

Parameters:
IN_FIFO_ADDR_WIDTH, 9, block buffer address width; depth = 2**IN_FIFO_ADDR_WIDTH blocks, max stored = 2**IN_FIFO_ADDR_WIDTH-1
IN_FIFO_DATA_WIDTH, 128, block width in bits; must equal 4*AXIS_DATA_WIDTH
AXIS_DATA_WIDTH, 32, stream word width

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
s_axis_tdata  input  AXIS_DATA_WIDTH  stream word
s_axis_tvalid  input  1  stream valid
s_axis_tlast  input  1  last word of packet
s_axis_tready  output  1  stream ready
aes_cmd  output  32  command word of current packet (to controller aes_cmd)
in_fifo_data  output  IN_FIFO_DATA_WIDTH  registered read data (to controller in_fifo_data)
in_fifo_blk_cnt  output  IN_FIFO_ADDR_WIDTH  complete blocks stored (to controller in_fifo_blk_cnt)
in_fifo_r_e  input  1  read enable (from controller)
in_fifo_addr  input  IN_FIFO_ADDR_WIDTH  read address (from controller)
ctrl_en  output  1  one-cycle start pulse (to controller en)
ctrl_done  input  1  completion pulse (from controller en_o)
err_o  output  1  sticky packet error flag

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: state=IDLE, aes_cmd=0, in_fifo_blk_cnt=0, in_fifo_data=0, ctrl_en=0, err_o=0.
  - Internal: word counter=0, write address=0.
  - Buffer contents are not reset.
  - Reset asserted mid-packet or mid-BUSY aborts immediately; the packet is lost.
- s_axis_tready = 1 only in RX_CMD and RX_DATA; it is decoded from the state register, with no combinational path from tvalid. Handshake = tvalid & tready.
- States:
  - IDLE: clear blk_cnt, write address, word counter and err_o -> RX_CMD next cycle (tready=0 for that one cycle).
  - RX_CMD: on handshake, aes_cmd <= tdata. If tlast -> START with blk_cnt=0; otherwise -> RX_DATA.
  - RX_DATA: on each handshake, place the word in slot word_cnt of the assembly register. Word 0 goes in bits [0:31], i.e. the MSB end of the [0:127] vector; no byte swapping, which the controller performs. word_cnt increments mod 4.
    - On the 4th word, write the assembled block (including the current word) to buffer[wr_addr]. wr_addr++ and blk_cnt++ in the same cycle.
    - Overflow: if blk_cnt == 2**IN_FIFO_ADDR_WIDTH-1 when a block completes, the block is not written, counters hold, err_o <= 1. Keep accepting words until tlast.
    - tlast on the 4th word -> START after the write.
    - tlast with word_cnt != 3: discard the partial block, err_o <= 1 -> START with the complete blocks only.
  - START: ctrl_en=1 for exactly one cycle -> BUSY.
  - BUSY: tready=0. aes_cmd and blk_cnt hold. On ctrl_done=1 -> IDLE.
- ctrl_done outside BUSY is ignored.
- Read port:
  - When in_fifo_r_e=1, in_fifo_data <= buffer[in_fifo_addr] at the rising edge: 1-cycle latency.
  - When in_fifo_r_e=0, in_fifo_data holds.
  - Reads are legal in any state. Data read in states other than BUSY is unspecified for the consumer.
  - Reads and writes never target the same cycle in normal operation. If they do, read-before-write (old data) applies.
- err_o stays set through BUSY and clears on entry to IDLE.
- Throughput: one word per cycle in RX states. Ingress turnaround is START + BUSY + IDLE.

Test Plan:
- Single block, normal case:
  - Stimulus: cmd=32'h20, words 00112233, 44556677, 8899aabb, ccddeeff (tlast on last word).
  - Required: blk_cnt=1, ctrl_en pulses once, buffer[0]=128'h00112233_44556677_8899aabb_ccddeeff, tready=0 until ctrl_done.
- Back-pressure and readback:
  - Stimulus: 3 blocks with tvalid toggling 1/0 every cycle.
  - Required: blk_cnt=3, no lost or duplicated words. r_e with addr 0,1,2 returns each block exactly one cycle after r_e.
- Command only:
  - Stimulus: cmd word with tlast.
  - Required: blk_cnt=0, ctrl_en pulse, err_o=0. ctrl_done -> IDLE -> tready=1 two cycles later.
- Partial block:
  - Stimulus: cmd + 6 words, tlast on word 6.
  - Required: blk_cnt=1, err_o=1 during BUSY, err_o=0 after return to IDLE.
- Overflow:
  - Stimulus: IN_FIFO_ADDR_WIDTH=2, send 4 blocks.
  - Required: blk_cnt=3, buffer[3] unwritten, err_o=1, tlast still accepted and ctrl_en pulses.
- Reset and spurious completion:
  - Stimulus: reset low mid-RX_DATA, then a new 1-block packet; also a spurious ctrl_done in RX_DATA.
  - Required: on reset, outputs immediately go to reset values. The new packet processes correctly, and the spurious ctrl_done causes no state change.

Source files
------------

// File: rtl/aes_in_stream_if.sv
// AXI4-Stream word channel feeding the AES ingress stage.
// The master drives tdata/tvalid/tlast, the slave drives tready.
interface aes_in_stream_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aes_in_stream.sv
// Ingress stage for aes_controller: takes one command+payload packet, packs payload
// into 128-bit blocks in a block buffer, starts the controller and serves its reads.
module aes_in_stream #(
    parameter int IN_FIFO_ADDR_WIDTH = 9,
    parameter int IN_FIFO_DATA_WIDTH = 128,
    parameter int AXIS_DATA_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    aes_in_stream_if.slave                s_axis,
    output logic [31:0]                   aes_cmd,
    output logic [IN_FIFO_DATA_WIDTH-1:0] in_fifo_data,
    output logic [IN_FIFO_ADDR_WIDTH-1:0] in_fifo_blk_cnt,
    input  logic                          in_fifo_r_e,
    input  logic [IN_FIFO_ADDR_WIDTH-1:0] in_fifo_addr,
    output logic                          ctrl_en,
    input  logic                          ctrl_done,
    output logic                          err_o,
    output logic [2:0]                    o_dbg_state
);

    localparam int DEPTH = 2 ** IN_FIFO_ADDR_WIDTH;
    localparam int ASM_W = IN_FIFO_DATA_WIDTH - AXIS_DATA_WIDTH;
    localparam logic [IN_FIFO_ADDR_WIDTH-1:0] BLK_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_CMD  = 3'd1,
        ST_RX_DATA = 3'd2,
        ST_START   = 3'd3,
        ST_BUSY    = 3'd4
    } state_t;

    // Stream handshake: a word transfers on a rising edge where tvalid & tready.
    // tready is decoded from the state register only, never from tvalid.

    state_t                          r_state;
    state_t                          w_next_state;
    logic [31:0]                     r_cmd;
    logic [IN_FIFO_ADDR_WIDTH-1:0]   r_blk_cnt;
    logic [IN_FIFO_ADDR_WIDTH-1:0]   r_wr_addr;
    logic [1:0]                      r_word_cnt;
    logic                            r_err;
    logic [ASM_W-1:0]                r_asm;
    logic [IN_FIFO_DATA_WIDTH-1:0]   r_rd_data;
    logic [IN_FIFO_DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic                            w_tready;
    logic                            w_ctrl_en;
    logic                            w_hs;
    logic                            w_blk_done;
    logic                            w_full;
    logic                            w_wr_en;
    logic [AXIS_DATA_WIDTH-1:0]      w_tdata;
    logic [IN_FIFO_DATA_WIDTH-1:0]   w_block;

    assign w_tdata    = s_axis.tdata;
    assign w_tready   = (r_state == ST_RX_CMD) || (r_state == ST_RX_DATA);
    assign w_ctrl_en  = (r_state == ST_START);
    assign w_hs       = s_axis.tvalid && w_tready;
    assign w_blk_done = (r_state == ST_RX_DATA) && w_hs && (r_word_cnt == 2'd3);
    assign w_full     = (r_blk_cnt == BLK_MAX);
    assign w_wr_en    = w_blk_done && !w_full;
    // Earlier words sit higher in the shift register, so word 0 lands at the MSB end.
    assign w_block    = {r_asm, w_tdata};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    w_next_state = ST_RX_CMD;
            ST_RX_CMD:  if (w_hs) w_next_state = s_axis.tlast ? ST_START : ST_RX_DATA;
            ST_RX_DATA: if (w_hs && s_axis.tlast) w_next_state = ST_START;
            ST_START:   w_next_state = ST_BUSY;
            ST_BUSY:    if (ctrl_done) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd      <= '0;
            r_blk_cnt  <= '0;
            r_wr_addr  <= '0;
            r_word_cnt <= '0;
            r_err      <= 1'b0;
            r_asm      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_blk_cnt  <= '0;
                    r_wr_addr  <= '0;
                    r_word_cnt <= '0;
                    r_err      <= 1'b0;
                end
                ST_RX_CMD: begin
                    if (w_hs) begin
                        r_cmd      <= w_tdata;
                        r_word_cnt <= '0;
                    end
                end
                ST_RX_DATA: begin
                    if (w_hs) begin
                        r_asm      <= {r_asm[ASM_W-AXIS_DATA_WIDTH-1:0], w_tdata};
                        r_word_cnt <= r_word_cnt + 2'd1;
                        if (w_blk_done) begin
                            // A full buffer drops the block but keeps draining the packet.
                            if (w_full) begin
                                r_err <= 1'b1;
                            end else begin
                                r_wr_addr <= r_wr_addr + 1'b1;
                                r_blk_cnt <= r_blk_cnt + 1'b1;
                            end
                        end else if (s_axis.tlast) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (ctrl_done) r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Block storage has no reset; contents survive across packets and resets.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_addr] <= w_block;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           r_rd_data <= '0;
        else if (in_fifo_r_e) r_rd_data <= r_mem[in_fifo_addr];
    end

    assign s_axis.tready   = w_tready;
    assign ctrl_en         = w_ctrl_en;
    assign aes_cmd         = r_cmd;
    assign in_fifo_blk_cnt = r_blk_cnt;
    assign in_fifo_data    = r_rd_data;
    assign err_o           = r_err;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_aes_in_stream.sv
// Bench for aes_in_stream: packet-level model of blocks/count/error checked by one
// compare process on every cycle, plus directed literal checks.
module tb_aes_in_stream;
  localparam int AW = 2;
  localparam int DW = 128;
  localparam int NB = 2 ** AW;
  localparam int MAXB = NB - 1;
  localparam int RECW = 32 + AW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] in_fifo_data;
  logic [AW-1:0] in_fifo_blk_cnt;
  logic in_fifo_r_e = 1'b0;
  logic [AW-1:0] in_fifo_addr = '0;
  logic [31:0] aes_cmd;
  logic ctrl_en;
  logic ctrl_done = 1'b0;
  logic err_o;
  logic [2:0] dbg_state;

  aes_in_stream_if #(.DW(32)) axis_if ();

  aes_in_stream #(
    .IN_FIFO_ADDR_WIDTH(AW),
    .IN_FIFO_DATA_WIDTH(DW),
    .AXIS_DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .s_axis(axis_if),
    .aes_cmd(aes_cmd),
    .in_fifo_data(in_fifo_data),
    .in_fifo_blk_cnt(in_fifo_blk_cnt),
    .in_fifo_r_e(in_fifo_r_e),
    .in_fifo_addr(in_fifo_addr),
    .ctrl_en(ctrl_en),
    .ctrl_done(ctrl_done),
    .err_o(err_o),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // model: expected packet records {cmd, blk_cnt, err} and buffer image
  logic [RECW-1:0] exp_q[$];
  logic [DW-1:0] mem_m [0:NB-1];
  bit mv [0:NB-1];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, expected normal progress", name);
  endtask

  // driver: one packet, cmd word then n payload words base + step*i
  task automatic send_packet(input logic [31:0] cmd, input int n, input logic [31:0] base,
                             input logic [31:0] step, input bit toggle, input int spur_at);
    logic [31:0] w[$];
    int idx, guard, nblk, stored;
    bit hs, phase, perr;
    w.push_back(cmd);
    for (int i = 0; i < n; i++) w.push_back(base + step * i);
    idx = 0; guard = 0; phase = 1'b1;
    while (idx < w.size() && guard < 1000) begin
      axis_if.tvalid = toggle ? phase : 1'b1;
      axis_if.tdata = w[idx];
      axis_if.tlast = (idx == w.size() - 1);
      ctrl_done = (idx == spur_at);
      @(negedge clk);
      hs = axis_if.tvalid && axis_if.tready;
      @(posedge clk); #1;
      if (hs) idx++;
      phase = !phase;
      guard++;
    end
    axis_if.tvalid = 1'b0;
    axis_if.tlast = 1'b0;
    ctrl_done = 1'b0;
    if (guard >= 1000) fail_now("tx_timeout");
    nblk = n / 4;
    stored = (nblk > MAXB) ? MAXB : nblk;
    for (int b = 0; b < stored; b++) begin
      mem_m[b] = {w[1 + 4*b], w[2 + 4*b], w[3 + 4*b], w[4 + 4*b]};
      mv[b] = 1'b1;
    end
    perr = (n % 4 != 0) || (nblk > MAXB);
    exp_q.push_back({cmd, AW'(stored), perr});
  endtask

  // driver: controller side, wait for start, read blocks 0..nrd-1, then complete
  task automatic serve(input int nrd);
    int g;
    g = 0;
    while (!ctrl_en && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) fail_now("start_timeout");
    for (int i = 0; i < nrd; i++) begin
      @(posedge clk); #1;
      in_fifo_r_e = 1'b1;
      in_fifo_addr = AW'(i);
    end
    @(posedge clk); #1;
    in_fifo_r_e = 1'b0;
    @(posedge clk); #1;
    ctrl_done = 1'b1;
    @(posedge clk); #1;
    ctrl_done = 1'b0;
  endtask

  // scoreboard / compare process
  logic [RECW-1:0] cur;
  bit busy = 0, pend_v = 0, chk_idle = 0;
  logic [DW-1:0] pend_d = '0, last_rd = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0; pend_v = 0; chk_idle = 0; last_rd = '0;
    end else begin
      if (pend_v) begin
        check("rd_data", in_fifo_data, pend_d);
        last_rd = pend_d;
        pend_v = 0;
      end else begin
        check("rd_hold", in_fifo_data, last_rd);
      end
      if (chk_idle) begin
        check("idle_err", err_o, 0);
        check("idle_tready", axis_if.tready, 0);
        chk_idle = 0;
      end
      if (busy) begin
        check("busy_tready", axis_if.tready, 0);
        check("busy_en", ctrl_en, 0);
        check("busy_cmd", aes_cmd, cur[RECW-1 -: 32]);
        check("busy_cnt", in_fifo_blk_cnt, cur[AW:1]);
        check("busy_err", err_o, cur[0]);
        if (ctrl_done) begin
          busy = 0;
          chk_idle = 1;
        end
      end else if (ctrl_en) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_start");
        end else begin
          cur = exp_q.pop_front();
          check("start_tready", axis_if.tready, 0);
          check("start_cmd", aes_cmd, cur[RECW-1 -: 32]);
          check("start_cnt", in_fifo_blk_cnt, cur[AW:1]);
          check("start_err", err_o, cur[0]);
          busy = 1;
        end
      end
      if (in_fifo_r_e && mv[in_fifo_addr]) begin
        pend_v = 1;
        pend_d = mem_m[in_fifo_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  logic [RECW-1:0] rec;
  logic [DW-1:0] blk;
  int g;
  bit hs;

  initial begin
    for (int i = 0; i < NB; i++) mv[i] = 1'b0;
    axis_if.tvalid = 1'b0;
    axis_if.tdata = '0;
    axis_if.tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tready", axis_if.tready, 0);
    check("rst_cmd", aes_cmd, 0);
    check("rst_cnt", in_fifo_blk_cnt, 0);
    check("rst_data", in_fifo_data, 0);
    check("rst_en", ctrl_en, 0);
    check("rst_err", err_o, 0);
    rst_n = 1'b1;

    // single block
    send_packet(32'h20, 4, 32'h0011_2233, 32'h4444_4444, 0, -1);
    blk = mem_m[0];
    check("model_blk0", blk, 128'h00112233_44556677_8899aabb_ccddeeff);
    serve(1);

    // back-pressure, 3 blocks, readback of all
    send_packet(32'h21, 12, 32'hA000_0001, 32'h0000_0101, 1, -1);
    serve(3);

    // command only; tready returns two edges after completion
    send_packet(32'h55, 0, 32'h0, 32'h0, 0, -1);
    rec = exp_q[exp_q.size() - 1];
    check("model_cmdonly", rec[AW:0], 0);
    serve(0);
    check("turn_tready0", axis_if.tready, 0);
    @(posedge clk); #1;
    check("turn_tready1", axis_if.tready, 1);

    // partial block
    send_packet(32'h66, 6, 32'hB000_0000, 32'h0000_0011, 0, -1);
    rec = exp_q[exp_q.size() - 1];
    check("model_partial", rec[AW:0], {2'd1, 1'b1});
    serve(1);

    // overflow: 4 blocks into a 3-block buffer
    send_packet(32'h77, 16, 32'hC000_0000, 32'h0001_0001, 0, -1);
    rec = exp_q[exp_q.size() - 1];
    check("model_ovf", rec[AW:0], {2'd3, 1'b1});
    serve(3);

    // reset in the middle of RX_DATA
    @(posedge clk); #1;
    axis_if.tvalid = 1'b1;
    axis_if.tdata = 32'h88;
    g = 0;
    hs = 0;
    while (!hs && g < 10) begin
      @(negedge clk);
      hs = axis_if.tready;
      @(posedge clk); #1;
      g++;
    end
    if (!hs) fail_now("rst_pkt_timeout");
    axis_if.tdata = 32'hE000_0000;
    @(posedge clk); #1;
    axis_if.tdata = 32'hE000_0001;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_tready", axis_if.tready, 0);
    check("arst_cmd", aes_cmd, 0);
    check("arst_cnt", in_fifo_blk_cnt, 0);
    check("arst_data", in_fifo_data, 0);
    check("arst_en", ctrl_en, 0);
    check("arst_err", err_o, 0);
    axis_if.tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // fresh packet with a spurious completion pulse during RX_DATA
    send_packet(32'h1234_5678, 4, 32'hDEAD_0000, 32'h0000_1111, 0, 2);
    serve(1);

    repeat (3) @(posedge clk);
    check("leftover_records", exp_q.size(), 0);
    check("final_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
